spikecnt_bank: RTL and testbench
================================

Name: spikecnt_bank

Overview:
- Multi-channel spike counter for a rack node. It counts spikes arriving on up to NCH inter-FPGA spike lines, or on local neuron spikes, over simulation-time windows.
- Each channel latches its count at the end of every window. Latched counts are read through one registered mux feeding OpalKelly wire-outs.
- It generalises the single-neuron spike counter with: channel count, counter width, input synchronisation depth, and a cumulative/windowed mode.

Parameters:
- NCH, 14, number of spike channels (1..64).
- CW, 32, counter width per channel.
- SYNC_STAGES, 2, flip-flop synchroniser depth on each spike input (>=1).
- SELW, 6, width of the read select bus; must satisfy 2^SELW >= NCH.

Ports:
- clk, input, 1, single system clock (rack clk1); all logic is on this edge.
- reset, input, 1, asynchronous active-high reset (driven from reset_global).
- spike_in, input, NCH, raw spike lines, asynchronous to clk; bit i is channel i.
- win_tick, input, 1, one-clk pulse marking the end of a 1 ms simulation window (sim_clk edge, synchronised upstream).
- cumulative, input, 1, 0 = windowed mode (clear on win_tick); 1 = running total, never cleared by win_tick.
- clear, input, 1, synchronous clear of all running counts, latched counts and frame_cnt.
- rd_sel, input, SELW, channel index to read.
- rd_data, output, CW, latched count of channel rd_sel.
- frame_cnt, output, 32, number of win_ticks since reset/clear; wraps.
- latch_valid, output, 1, one-clk pulse, cycle after latched counts update.
- sat_flags, output, NCH, sticky per-channel saturation flag.

Behaviour:
- Reset (async, active-high): running counts, latched counts, synchroniser flops, edge-detect history, rd_data, frame_cnt, latch_valid and sat_flags all go to 0 immediately. Reset is released synchronously.
- Input path: each spike_in[i] passes through SYNC_STAGES flops, then a rising-edge detector.
  - One event equals a 0->1 transition of the synchronised signal.
  - A level held high counts once.
  - Event latency from the input edge is SYNC_STAGES+1 clk.
- Counting: on an event, run[i] <= run[i]+1, unless run[i] == 2^CW-1.
  - At 2^CW-1 the counter holds (saturates) and sat_flags[i] is set.
  - sat_flags clears only on reset or clear.
- win_tick in windowed mode (cumulative=0):
  - lat[i] <= run[i] + (event_i ? 1 : 0), still saturating.
  - run[i] <= 0.
  - Net rule: an event coincident with win_tick belongs to the window that is closing.
- win_tick in cumulative mode (cumulative=1):
  - lat[i] <= run[i] + event_i, saturating; run[i] is not cleared.
- On every win_tick (either mode):
  - frame_cnt <= frame_cnt+1, wrapping 2^32-1 -> 0.
  - latch_valid pulses high exactly one clk after the win_tick cycle.
- Back-to-back win_tick on consecutive clks is legal; each one closes a window, and the second window may be 0.
- clear:
  - Synchronous; has priority over win_tick and events in the same cycle.
  - Zeroes run, lat, frame_cnt and sat_flags.
  - Produces no latch_valid pulse.
  - The synchroniser and edge history are not cleared, so a line held high does not produce a false event after clear.
- Toggling cumulative mid-window takes effect the next cycle. Counts are not modified at the toggle.
- Readout:
  - rd_data <= lat[rd_sel], registered, 1 clk latency.
  - rd_sel >= NCH yields rd_data = 0.
  - If lat updates in the same cycle rd_sel is sampled, rd_data shows the pre-update value; the new value appears one clk later.
- Widths: all arithmetic is unsigned, CW bits, with no wrap on channel counters. frame_cnt is the only wrapping counter.
- Reset asserted mid-window discards all counts; no latch occurs.

Test Plan:
- Reset, then 5 isolated pulses on spike_in[0] (each 3 clk high, 10 clk apart), then win_tick -> next clk latch_valid=1; rd_sel=0 gives rd_data=5 after 1 clk; frame_cnt=1; other channels read 0.
- spike_in[3] held high for 200 clk across two win_ticks -> window 1 latches 1, window 2 latches 0.
- Event edge arriving exactly in the win_tick cycle on channel 2, with 4 prior events -> lat[2]=5, run[2]=0 afterwards; the next window starts at 0.
- CW=4, cumulative=1: 20 events on channel 1 with a win_tick after every 5 -> latched 5, 10, 15, then 15 with sat_flags[1]=1; clear -> all outputs 0, with no latch_valid pulse.
- Same-cycle clear and win_tick -> frame_cnt=0, lat all 0, latch_valid stays 0. Then rd_sel=NCH+1 -> rd_data=0.
- Assert reset 20 clk into a window with 7 counts pending on all channels -> everything 0 immediately. After release, 2 events then win_tick -> each channel latches 2; frame_cnt=1.

Source files
------------

// File: rtl/spikecnt_bank.sv
// Multi-channel spike counter bank: synchronised edge counting per channel,
// window latching on win_tick and a registered readout mux.
module spikecnt_bank #(
    parameter int unsigned NCH         = 14,
    parameter int unsigned CW          = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SELW        = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NCH-1:0]  spike_in,
    input  logic            win_tick,
    input  logic            cumulative,
    input  logic            clear,
    input  logic [SELW-1:0] rd_sel,
    output logic [CW-1:0]   rd_data,
    output logic [31:0]     frame_cnt,
    output logic            latch_valid,
    output logic [NCH-1:0]  sat_flags
);

    logic [NCH-1:0] sync_q [SYNC_STAGES];
    logic [NCH-1:0] hist_q;
    logic [NCH-1:0] ev;
    logic [NCH-1:0] sat_hit;
    logic [CW-1:0]  run_q [NCH];
    logic [CW-1:0]  lat_q [NCH];
    logic [CW-1:0]  inc   [NCH];
    logic [CW-1:0]  rd_next;

    // Synchroniser and edge history survive clear so a held line cannot re-trigger.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            hist_q <= '0;
        end else begin
            sync_q[0] <= spike_in;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        ev      = sync_q[SYNC_STAGES-1] & ~hist_q;
        sat_hit = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            inc[i] = run_q[i];
            if (ev[i]) begin
                if (run_q[i] == '1) begin
                    sat_hit[i] = 1'b1;
                end else begin
                    inc[i] = run_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                run_q[i] <= '0;
                lat_q[i] <= '0;
            end
            frame_cnt   <= '0;
            latch_valid <= 1'b0;
            sat_flags   <= '0;
        end else if (clear) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                run_q[i] <= '0;
                lat_q[i] <= '0;
            end
            frame_cnt   <= '0;
            latch_valid <= 1'b0;
            sat_flags   <= '0;
        end else begin
            latch_valid <= win_tick;
            sat_flags   <= sat_flags | sat_hit;
            if (win_tick) begin
                frame_cnt <= frame_cnt + 32'd1;
            end
            // A coincident event is folded into the closing window via inc[].
            for (int unsigned i = 0; i < NCH; i++) begin
                if (win_tick) begin
                    lat_q[i] <= inc[i];
                    run_q[i] <= cumulative ? inc[i] : '0;
                end else begin
                    run_q[i] <= inc[i];
                end
            end
        end
    end

    always_comb begin
        rd_next = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (rd_sel == SELW'(i)) begin
                rd_next = lat_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_spikecnt_bank.sv
// Directed self-checking bench for spikecnt_bank (default widths and a CW=4 instance).
module tb_spikecnt_bank;

    localparam int unsigned NCH  = 14;
    localparam int unsigned SELW = 6;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NCH-1:0]  spike_in = '0;
    logic            win_tick = 1'b0;
    logic            cumulative = 1'b0;
    logic            clear = 1'b0;
    logic [SELW-1:0] rd_sel = '0;

    logic [31:0]     rd_data;
    logic [31:0]     frame_cnt;
    logic            latch_valid;
    logic [NCH-1:0]  sat_flags;

    logic [3:0]      rd_data4;
    logic [31:0]     frame_cnt4;
    logic            latch_valid4;
    logic [NCH-1:0]  sat_flags4;

    int checks = 0;
    int errors = 0;

    spikecnt_bank #(.NCH(NCH), .CW(32), .SYNC_STAGES(2), .SELW(SELW)) dut (
        .clk(clk), .reset(reset), .spike_in(spike_in), .win_tick(win_tick),
        .cumulative(cumulative), .clear(clear), .rd_sel(rd_sel),
        .rd_data(rd_data), .frame_cnt(frame_cnt), .latch_valid(latch_valid),
        .sat_flags(sat_flags)
    );

    spikecnt_bank #(.NCH(NCH), .CW(4), .SYNC_STAGES(2), .SELW(SELW)) dut4 (
        .clk(clk), .reset(reset), .spike_in(spike_in), .win_tick(win_tick),
        .cumulative(cumulative), .clear(clear), .rd_sel(rd_sel),
        .rd_data(rd_data4), .frame_cnt(frame_cnt4), .latch_valid(latch_valid4),
        .sat_flags(sat_flags4)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        spike_in = '0;
        win_tick = 1'b0;
        clear = 1'b0;
        cumulative = 1'b0;
        rd_sel = '0;
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(1);
    endtask

    task automatic pulse(input logic [NCH-1:0] mask, input int hi, input int lo);
        spike_in = spike_in | mask;
        wait_cyc(hi);
        spike_in = spike_in & ~mask;
        wait_cyc(lo);
    endtask

    task automatic win();
        win_tick = 1'b1;
        wait_cyc(1);
        win_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_cyc(2);
        checks++;
        if (rd_data !== 32'd0 || frame_cnt !== 32'd0 || latch_valid !== 1'b0 || sat_flags !== '0) begin
            errors++;
            $display("FAIL reset_state: rd=%0d frame=%0d lv=%0b sat=%h required all 0", rd_data, frame_cnt, latch_valid, sat_flags);
        end
        reset = 1'b0;
        wait_cyc(1);
    endtask

    task automatic test_basic();
        do_reset();
        for (int k = 0; k < 5; k++) pulse(14'h1, 3, 10);
        win();
        checks++;
        if (latch_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_latch_valid: got %0b required 1", latch_valid);
        end
        checks++;
        if (frame_cnt !== 32'd1) begin
            errors++;
            $display("FAIL basic_frame: got %0d required 1", frame_cnt);
        end
        checks++;
        if (rd_data !== 32'd0) begin
            errors++;
            $display("FAIL basic_rd_pre_update: got %0d required 0", rd_data);
        end
        wait_cyc(1);
        checks++;
        if (rd_data !== 32'd5 || latch_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_rd_ch0: rd=%0d lv=%0b required rd=5 lv=0", rd_data, latch_valid);
        end
        rd_sel = 6'd1;
        wait_cyc(1);
        checks++;
        if (rd_data !== 32'd0) begin
            errors++;
            $display("FAIL basic_rd_ch1: got %0d required 0", rd_data);
        end
    endtask

    task automatic test_level();
        do_reset();
        rd_sel = 6'd3;
        spike_in[3] = 1'b1;
        wait_cyc(50);
        win();
        wait_cyc(1);
        checks++;
        if (rd_data !== 32'd1) begin
            errors++;
            $display("FAIL level_win1: got %0d required 1", rd_data);
        end
        wait_cyc(50);
        win();
        checks++;
        if (rd_data !== 32'd1) begin
            errors++;
            $display("FAIL level_win2_pre: got %0d required 1", rd_data);
        end
        wait_cyc(1);
        checks++;
        if (rd_data !== 32'd0 || frame_cnt !== 32'd2) begin
            errors++;
            $display("FAIL level_win2: rd=%0d frame=%0d required rd=0 frame=2", rd_data, frame_cnt);
        end
        wait_cyc(97);
        spike_in[3] = 1'b0;
        wait_cyc(5);
    endtask

    task automatic test_coincident();
        do_reset();
        rd_sel = 6'd2;
        for (int k = 0; k < 4; k++) pulse(14'h4, 3, 3);
        spike_in[2] = 1'b1;
        wait_cyc(2);
        win();
        wait_cyc(1);
        checks++;
        if (rd_data !== 32'd5) begin
            errors++;
            $display("FAIL coincident_lat: got %0d required 5", rd_data);
        end
        wait_cyc(10);
        spike_in[2] = 1'b0;
        wait_cyc(5);
        win();
        wait_cyc(1);
        checks++;
        if (rd_data !== 32'd0) begin
            errors++;
            $display("FAIL coincident_next_window: got %0d required 0", rd_data);
        end
    endtask

    task automatic test_saturation();
        logic [3:0]     exp_v;
        logic [NCH-1:0] exp_s;
        do_reset();
        cumulative = 1'b1;
        rd_sel = 6'd1;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 5; j++) pulse(14'h2, 3, 3);
            win();
            wait_cyc(1);
            exp_v = (k < 3) ? 4'(5 * (k + 1)) : 4'd15;
            exp_s = (k == 3) ? 14'h2 : 14'h0;
            checks++;
            if (rd_data4 !== exp_v || sat_flags4 !== exp_s) begin
                errors++;
                $display("FAIL sat_window%0d: rd=%0d sat=%h required rd=%0d sat=%h", k, rd_data4, sat_flags4, exp_v, exp_s);
            end
        end
        checks++;
        if (frame_cnt4 !== 32'd4) begin
            errors++;
            $display("FAIL sat_frame: got %0d required 4", frame_cnt4);
        end
        clear = 1'b1;
        wait_cyc(1);
        clear = 1'b0;
        checks++;
        if (latch_valid4 !== 1'b0 || frame_cnt4 !== 32'd0 || sat_flags4 !== '0) begin
            errors++;
            $display("FAIL sat_clear: lv=%0b frame=%0d sat=%h required all 0", latch_valid4, frame_cnt4, sat_flags4);
        end
        wait_cyc(1);
        checks++;
        if (rd_data4 !== 4'd0 || latch_valid4 !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear_rd: rd=%0d lv=%0b required rd=0 lv=0", rd_data4, latch_valid4);
        end
        cumulative = 1'b0;
    endtask

    task automatic test_clear_win();
        do_reset();
        for (int k = 0; k < 3; k++) pulse(14'h1, 3, 3);
        win();
        for (int k = 0; k < 2; k++) pulse(14'h1, 3, 3);
        clear = 1'b1;
        win_tick = 1'b1;
        wait_cyc(1);
        clear = 1'b0;
        win_tick = 1'b0;
        checks++;
        if (latch_valid !== 1'b0 || frame_cnt !== 32'd0) begin
            errors++;
            $display("FAIL clear_win: lv=%0b frame=%0d required lv=0 frame=0", latch_valid, frame_cnt);
        end
        wait_cyc(1);
        checks++;
        if (rd_data !== 32'd0 || latch_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_win_lat: rd=%0d lv=%0b required rd=0 lv=0", rd_data, latch_valid);
        end
        for (int k = 0; k < 2; k++) pulse(14'h2001, 3, 3);
        win();
        wait_cyc(1);
        checks++;
        if (rd_data !== 32'd2 || frame_cnt !== 32'd1) begin
            errors++;
            $display("FAIL clear_win_after: rd=%0d frame=%0d required rd=2 frame=1", rd_data, frame_cnt);
        end
        rd_sel = 6'd13;
        wait_cyc(1);
        checks++;
        if (rd_data !== 32'd2) begin
            errors++;
            $display("FAIL rd_last_channel: got %0d required 2", rd_data);
        end
        rd_sel = 6'(NCH + 1);
        wait_cyc(1);
        checks++;
        if (rd_data !== 32'd0) begin
            errors++;
            $display("FAIL rd_out_of_range: got %0d required 0", rd_data);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rd_sel = 6'd5;
        for (int k = 0; k < 3; k++) pulse('1, 3, 3);
        win();
        wait_cyc(1);
        checks++;
        if (rd_data !== 32'd3) begin
            errors++;
            $display("FAIL reset_mid_pre: got %0d required 3", rd_data);
        end
        for (int k = 0; k < 7; k++) pulse('1, 3, 3);
        wait_cyc(20);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (rd_data !== 32'd0 || frame_cnt !== 32'd0 || latch_valid !== 1'b0 || sat_flags !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: rd=%0d frame=%0d lv=%0b sat=%h required all 0", rd_data, frame_cnt, latch_valid, sat_flags);
        end
        wait_cyc(1);
        reset = 1'b0;
        wait_cyc(1);
        for (int k = 0; k < 2; k++) pulse('1, 3, 3);
        win();
        checks++;
        if (frame_cnt !== 32'd1) begin
            errors++;
            $display("FAIL reset_mid_frame: got %0d required 1", frame_cnt);
        end
        for (int i = 0; i < NCH; i++) begin
            rd_sel = 6'(i);
            wait_cyc(1);
            checks++;
            if (rd_data !== 32'd2 || rd_data4 !== 4'd2) begin
                errors++;
                $display("FAIL reset_mid_ch%0d: rd=%0d rd4=%0d required 2", i, rd_data, rd_data4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_level();
        test_coincident();
        test_saturation();
        test_clear_win();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
